systolic_ctrl: RTL

Sequencer for an N×N output-stationary systolic array of multiply-accumulate PEs. It accepts a tile job (start + inner length), clears the PE accumulators, and drives the array enable for exactly the skewed feed window. It generates the per-row/per-column operand-valid masks used by the array-edge zero-muxes, then drains the N result rows through a valid/ready port. It sits between the tile scheduler and the PE array plus its A/B operand buffers.

---
 rtl/systolic_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary systolic MAC array.
// Accepts a tile job (start + inner length K), clears the PE accumulators,
// enables the array for the skewed feed window, and generates the per-row and
// per-column operand-valid masks. It then drains the N result rows through a
// valid/ready port.
// Optional feature macro: SYSCTRL_ACCUM_EN adds an 'accum' input that skips
// the CLEAR cycle, so results accumulate onto the previous tile.
module systolic_ctrl #(
    parameter int unsigned N    = 4,
    parameter int unsigned KMAX = 8,
    parameter int unsigned STW  = $clog2(KMAX + 2 * N - 1),
    parameter int unsigned KW   = $clog2(KMAX + 1),
    localparam int unsigned RW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  k_len,
`ifdef SYSCTRL_ACCUM_EN
    input  logic           accum,
`endif
    output logic           busy,
    output logic           done,
    output logic           pe_clr,
    output logic           pe_en,
    output logic [STW-1:0] step,
    output logic [N-1:0]   a_vld,
    output logic [N-1:0]   b_vld,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [RW-1:0]  res_row
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e         state_q;
    logic [KW-1:0]  k_q;
    logic           busy_q;
    logic           done_q;
    logic           pe_clr_q;
    logic           pe_en_q;
    logic [STW-1:0] step_q;
    logic [N-1:0]   a_vld_q;
    logic [N-1:0]   b_vld_q;
    logic [RW-1:0]  res_row_q;

    logic [KW-1:0]  k_in;
    logic           feed_last;
    logic           skip_clr;

    // Edge lane x is live at step t while operand index t-x lies inside [0, K).
    function automatic logic [N-1:0] edge_mask(input logic [STW-1:0] t, input logic [KW-1:0] k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < int'(N); i++) begin
            m[i] = (int'(t) >= i) && ((int'(t) - i) < int'(k));
        end
        return m;
    endfunction

`ifdef SYSCTRL_ACCUM_EN
    assign skip_clr = accum;
`else
    assign skip_clr = 1'b0;
`endif

    // Clamp the requested inner length and detect the final feed step (K+2N-3).
    always_comb begin
        k_in      = (int'(k_len) > int'(KMAX)) ? KW'(KMAX) : k_len;
        feed_last = (int'(step_q) == (int'(k_q) + 2 * int'(N) - 3));
    end

    // Job sequencer; every output except res_valid is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pe_clr_q  <= 1'b0;
            pe_en_q   <= 1'b0;
            step_q    <= '0;
            a_vld_q   <= '0;
            b_vld_q   <= '0;
            res_row_q <= '0;
        end else begin
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q    <= k_in;
                        busy_q <= 1'b1;
                        if (!skip_clr) begin
                            state_q  <= StClear;
                            pe_clr_q <= 1'b1;
                        end else if (k_in != '0) begin
                            state_q <= StFeed;
                            pe_en_q <= 1'b1;
                            step_q  <= '0;
                            a_vld_q <= edge_mask('0, k_in);
                            b_vld_q <= edge_mask('0, k_in);
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StClear: begin
                    // K=0 has nothing to feed; the cleared array drains as zeros.
                    if (k_q != '0) begin
                        state_q <= StFeed;
                        pe_en_q <= 1'b1;
                        step_q  <= '0;
                        a_vld_q <= edge_mask('0, k_q);
                        b_vld_q <= edge_mask('0, k_q);
                    end else begin
                        state_q <= StDrain;
                    end
                end
                StFeed: begin
                    if (feed_last) begin
                        state_q <= StDrain;
                        pe_en_q <= 1'b0;
                        step_q  <= '0;
                        a_vld_q <= '0;
                        b_vld_q <= '0;
                    end else begin
                        step_q  <= step_q + STW'(1);
                        a_vld_q <= edge_mask(step_q + STW'(1), k_q);
                        b_vld_q <= edge_mask(step_q + STW'(1), k_q);
                    end
                end
                StDrain: begin
                    if (res_ready) begin
                        if (res_row_q == RW'(N - 1)) begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            res_row_q <= '0;
                        end else begin
                            res_row_q <= res_row_q + RW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = (state_q == StDrain);
    assign busy      = busy_q;
    assign done      = done_q;
    assign pe_clr    = pe_clr_q;
    assign pe_en     = pe_en_q;
    assign step      = step_q;
    assign a_vld     = a_vld_q;
    assign b_vld     = b_vld_q;
    assign res_row   = res_row_q;

endmodule
